// File: rtl/sevenseg_scan_decoder_if.sv
// Multiplexed seven-segment bus as seen by the scan decoder, plus the decoded results.
interface sevenseg_scan_decoder_if;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] d3;
  logic [3:0] d2;
  logic [3:0] d1;
  logic [3:0] d0;
  logic [3:0] dp_out;
  logic [3:0] digit_valid;
  logic       frame_valid;
  logic       err_multi;
  logic       err_pattern;

  modport master (
    output an, seg, dp,
    input  d3, d2, d1, d0, dp_out, digit_valid, frame_valid, err_multi, err_pattern
  );

  modport slave (
    input  an, seg, dp,
    output d3, d2, d1, d0, dp_out, digit_valid, frame_valid, err_multi, err_pattern
  );
endinterface

// File: rtl/sevenseg_scan_decoder.sv
// Watches a multiplexed seven-segment bus, waits for each scan slot to settle,
// decodes the lit segments back to a digit value and reports frame completion.
module sevenseg_scan_decoder #(
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1,
  parameter int unsigned STABLE_CYCLES  = 4,
  parameter logic [3:0]  DIGIT_MASK     = 4'b0011
) (
  input logic                    clk,
  input logic                    rst_n,
  sevenseg_scan_decoder_if.slave bus
);
  localparam int unsigned NDIG  = 4;
  localparam int unsigned SEGW  = 7;
  localparam int unsigned SNAPW = NDIG + SEGW + 1;
  localparam int unsigned CNTW  = 8;

  localparam logic [CNTW-1:0]  CNT_HOLD  = CNTW'(STABLE_CYCLES);
  localparam logic [CNTW-1:0]  CNT_LAST  = CNTW'(STABLE_CYCLES - 1);
  localparam logic [SNAPW-1:0] SNAP_IDLE = {{NDIG{AN_ACTIVE_LOW}}, {SEGW{SEG_ACTIVE_LOW}}, SEG_ACTIVE_LOW};

  localparam logic [0:0] SETTLE = 1'b0;
  localparam logic [0:0] HOLD   = 1'b1;

  logic [SNAPW-1:0]          snap_q, snap_d, snap_c;
  logic [CNTW-1:0]           cnt_q, cnt_d;
  logic [0:0]                state_q, state_d;
  logic [NDIG-1:0][3:0]      dig_q, dig_d;
  logic [NDIG-1:0]           dp_q, dp_d;
  logic [NDIG-1:0]           valid_q, valid_d;
  logic [NDIG-1:0]           seen_q, seen_d;
  logic                      frame_q, frame_d;
  logic                      multi_q, multi_d;
  logic                      pattern_q, pattern_d;

  logic [NDIG-1:0]           en_c;
  logic [SEGW-1:0]           lit_c;
  logic                      dp_lit_c;
  logic [2:0]                n_en_c;
  logic [1:0]                idx_c;
  logic                      capture_c;
  logic [3:0]                code_c;
  logic [NDIG-1:0]           seen_new_c;

  // Segment pattern (gfedcba, 1 = lit) back to a digit; blank is F, junk is E.
  function automatic logic [3:0] decode(input logic [SEGW-1:0] lit);
    case (lit)
      7'b0111111: decode = 4'h0;
      7'b0000110: decode = 4'h1;
      7'b1011011: decode = 4'h2;
      7'b1001111: decode = 4'h3;
      7'b1100110: decode = 4'h4;
      7'b1101101: decode = 4'h5;
      7'b1111101: decode = 4'h6;
      7'b0000111: decode = 4'h7;
      7'b1111111: decode = 4'h8;
      7'b1101111: decode = 4'h9;
      7'b0000000: decode = 4'hF;
      default:    decode = 4'hE;
    endcase
  endfunction

  assign snap_c   = {bus.an, bus.seg, bus.dp};
  assign en_c     = AN_ACTIVE_LOW  ? ~bus.an  : bus.an;
  assign lit_c    = SEG_ACTIVE_LOW ? ~bus.seg : bus.seg;
  assign dp_lit_c = SEG_ACTIVE_LOW ? ~bus.dp  : bus.dp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      snap_q    <= SNAP_IDLE;
      cnt_q     <= CNT_HOLD;
      state_q   <= HOLD;
      dig_q     <= {NDIG{4'hF}};
      dp_q      <= '0;
      valid_q   <= '0;
      seen_q    <= '0;
      frame_q   <= 1'b0;
      multi_q   <= 1'b0;
      pattern_q <= 1'b0;
    end else begin
      snap_q    <= snap_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      dig_q     <= dig_d;
      dp_q      <= dp_d;
      valid_q   <= valid_d;
      seen_q    <= seen_d;
      frame_q   <= frame_d;
      multi_q   <= multi_d;
      pattern_q <= pattern_d;
    end
  end

  always_comb begin
    snap_d     = snap_q;
    cnt_d      = cnt_q;
    state_d    = state_q;
    dig_d      = dig_q;
    dp_d       = dp_q;
    valid_d    = valid_q;
    seen_d     = seen_q;
    frame_d    = 1'b0;
    multi_d    = 1'b0;
    pattern_d  = 1'b0;
    n_en_c     = '0;
    idx_c      = '0;
    capture_c  = 1'b0;
    code_c     = decode(lit_c);
    seen_new_c = seen_q;

    for (int i = 0; i < NDIG; i++) begin
      if (en_c[i]) begin
        n_en_c = n_en_c + 3'(en_c[i]);
        idx_c  = 2'(i);
      end
    end

    // Any bus change restarts settling; capture fires once, on the last settling edge.
    if (snap_c != snap_q) begin
      snap_d  = snap_c;
      cnt_d   = '0;
      state_d = SETTLE;
    end else if (cnt_q != CNT_HOLD) begin
      cnt_d     = cnt_q + 8'd1;
      state_d   = (cnt_q == CNT_LAST) ? HOLD : SETTLE;
      capture_c = (state_q == SETTLE) && (cnt_q == CNT_LAST);
    end

    if (capture_c) begin
      if (n_en_c > 3'd1) begin
        multi_d = 1'b1;
      end else if (n_en_c == 3'd1) begin
        dig_d[idx_c]   = code_c;
        dp_d[idx_c]    = dp_lit_c;
        valid_d[idx_c] = 1'b1;
        pattern_d      = (code_c == 4'hE);
        seen_new_c     = seen_q | (4'b0001 << idx_c);
        // An empty mask can never complete a frame.
        if ((DIGIT_MASK != 4'b0000) && ((seen_new_c & DIGIT_MASK) == DIGIT_MASK)) begin
          frame_d = 1'b1;
          seen_d  = '0;
        end else begin
          seen_d  = seen_new_c;
        end
      end
    end
  end

  assign bus.d0          = dig_q[0];
  assign bus.d1          = dig_q[1];
  assign bus.d2          = dig_q[2];
  assign bus.d3          = dig_q[3];
  assign bus.dp_out      = dp_q;
  assign bus.digit_valid = valid_q;
  assign bus.frame_valid = frame_q;
  assign bus.err_multi   = multi_q;
  assign bus.err_pattern = pattern_q;
endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Scoreboard bench for sevenseg_scan_decoder: slot-level reference model feeds a queue,
// a negedge monitor compares every cycle against it.
module tb_sevenseg_scan_decoder;
  localparam int unsigned STABLE = 4;
  localparam logic [3:0]  MASK   = 4'b0011;
  localparam logic [11:0] IDLE   = {4'hF, 7'h7F, 1'b1};
  localparam logic [6:0]  PAT [10] = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                                      7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};

  typedef struct {
    int         at_cyc;
    logic [15:0] d;
    logic [3:0]  dp;
    logic [3:0]  valid;
    logic [2:0]  pulses;  // {frame, multi, pattern}
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  // Reference model state, owned by the stimulus process.
  logic [3:0]  m_d [4];
  logic [3:0]  m_dp, m_valid, m_seen;
  logic [11:0] prev;

  // Expected steady display state, owned by the monitor.
  logic [15:0] cur_d;
  logic [3:0]  cur_dp, cur_valid;

  sevenseg_scan_decoder_if bus ();

  sevenseg_scan_decoder #(
    .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1), .STABLE_CYCLES(STABLE), .DIGIT_MASK(MASK)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  function automatic logic [3:0] decode_ref(input logic [6:0] lit);
    if (lit == 7'h00) return 4'hF;
    for (int i = 0; i < 10; i++) if (lit == PAT[i]) return 4'(i);
    return 4'hE;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_d[i] = 4'hF;
    m_dp = '0; m_valid = '0; m_seen = '0; prev = IDLE;
  endtask

  // Drive one slot for len edges; a slot seen for at least STABLE+1 edges is captured
  // STABLE edges after its first sampling edge.
  task automatic drive_slot(input logic [3:0] an, input logic [6:0] seg, input logic dp, input int len);
    logic [11:0] v;
    logic [3:0]  en, val;
    int          ones, idx;
    exp_t        e;
    v = {an, seg, dp};
    bus.an = an; bus.seg = seg; bus.dp = dp;
    if (v != prev && len >= int'(STABLE) + 1) begin
      en = ~an;
      ones = $countones(en);
      idx = 0;
      e.pulses = '0;
      if (ones >= 2) e.pulses[1] = 1'b1;
      else if (ones == 1) begin
        for (int i = 0; i < 4; i++) if (en[i]) idx = i;
        val = decode_ref(~seg);
        m_d[idx] = val; m_dp[idx] = ~dp; m_valid[idx] = 1'b1; m_seen[idx] = 1'b1;
        if (val == 4'hE) e.pulses[0] = 1'b1;
        if (MASK != 4'b0000 && (m_seen & MASK) == MASK) begin
          e.pulses[2] = 1'b1;
          m_seen = '0;
        end
      end
      e.at_cyc = cyc + 1 + int'(STABLE);
      e.d = {m_d[3], m_d[2], m_d[1], m_d[0]};
      e.dp = m_dp;
      e.valid = m_valid;
      sb.push_back(e);
    end
    prev = v;
    repeat (len) @(posedge clk);
    #1;
  endtask

  // Monitor: reset values during reset, full compare on capture edges, quiet otherwise.
  always @(negedge clk) begin
    exp_t e;
    logic [26:0] got;
    got = {bus.d3, bus.d2, bus.d1, bus.d0, bus.dp_out, bus.digit_valid,
           bus.frame_valid, bus.err_multi, bus.err_pattern};
    if (!rst_n) begin
      cur_d = 16'hFFFF; cur_dp = '0; cur_valid = '0;
      check("reset", 32'(got), 32'({16'hFFFF, 4'h0, 4'h0, 3'b000}));
    end else if (sb.size() > 0 && sb[0].at_cyc == cyc) begin
      e = sb.pop_front();
      check("digits", 32'(got[26:11]), 32'(e.d));
      check("dp_out", 32'(got[10:7]), 32'(e.dp));
      check("digit_valid", 32'(got[6:3]), 32'(e.valid));
      check("pulses", 32'(got[2:0]), 32'(e.pulses));
      cur_d = e.d; cur_dp = e.dp; cur_valid = e.valid;
    end else begin
      check("quiet", 32'(got), 32'({cur_d, cur_dp, cur_valid, 3'b000}));
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    int         k;
    rst_n = 1'b0;
    bus.an = IDLE[11:8]; bus.seg = IDLE[7:1]; bus.dp = IDLE[0];
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Idle bus after reset must stay silent.
    repeat (50) @(posedge clk);
    #1;

    // Scan of 42 completes a frame on the d1 capture.
    drive_slot(4'b1110, ~PAT[2], 1'b1, 8);
    drive_slot(4'b1101, ~PAT[4], 1'b1, 8);

    // Slot of exactly STABLE edges is cut on its capture edge; one more edge captures.
    drive_slot(4'b1110, ~PAT[7], 1'b1, STABLE);
    drive_slot(4'b1110, ~PAT[5], 1'b1, STABLE + 1);

    drive_slot(4'b1100, ~PAT[3], 1'b1, 8);
    drive_slot(4'b1110, ~7'b1000001, 1'b1, 8);
    drive_slot(4'b1110, 7'h7F, 1'b1, 8);
    drive_slot(4'b1110, ~PAT[1], 1'b0, 6);
    drive_slot(4'b0111, ~PAT[8], 1'b0, 6);

    for (int n = 0; n < 300; n++) begin
      k = $urandom_range(0, 9);
      if (k == 0)      an = 4'hF;
      else if (k == 1) an = ~(4'b0011 << $urandom_range(0, 2));
      else             an = ~(4'b0001 << $urandom_range(0, 3));
      k = $urandom_range(0, 10);
      if ($urandom_range(0, 4) == 0) seg = 7'($urandom);
      else if (k == 10)              seg = 7'h7F;
      else                           seg = ~PAT[k];
      dp = 1'($urandom);
      if ({an, seg, dp} == prev) dp = ~dp;
      drive_slot(an, seg, dp, $urandom_range(1, 9));
    end

    // Async reset mid-frame: d1 slot interrupted, frame needs both digits again.
    drive_slot(4'b1110, ~PAT[6], 1'b1, 8);
    drive_slot(4'b1101, ~PAT[9], 1'b1, 2);
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive_slot(4'b1101, ~PAT[9], 1'b1, 8);
    drive_slot(4'b1110, ~PAT[6], 1'b1, 8);
    drive_slot(4'hF, 7'h7F, 1'b1, 10);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
